// File: rtl/packet_bram_pkg.sv
// Shared FSM type and compile-time geometry helpers for the packet BRAM writer.
// Latency: none, elaboration-time constants only.
// Backpressure: none.
package packet_bram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Bit width able to index v items; never below one bit so ports stay legal.
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Words reserved per ping-pong bank.
   function automatic int calc_stride(input int depth_words, input int banks);
      return depth_words / banks;
   endfunction

   // Whole packets that fit in one bank; the remainder of the bank stays unused.
   function automatic int calc_ppb(input int depth_words, input int banks, input int pkt_words);
      return calc_stride(depth_words, banks) / pkt_words;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
// Latency: a pushed word is visible on rd_data_o the cycle after the push.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module sync_fifo_fwft
   import packet_bram_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          clear_i,
   input  logic                          wr_en_i,
   input  logic [WIDTH-1:0]              wr_data_i,
   input  logic                          rd_en_i,
   output logic [WIDTH-1:0]              rd_data_o,
   output logic                          empty_o,
   output logic                          full_o,
   output logic [fifo_cnt_w(DEPTH)-1:0]  count_o
);

   localparam int PTR_W = clog2_min1(DEPTH);
   localparam int CNT_W = fifo_cnt_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign push      = wr_en_i & ~full_o;
   assign pop       = rd_en_i & ~empty_o;

   // Pointer and count next-state; a flush wins over any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until the count covers them.
   always_ff @(posedge clk) begin
      if (push && !clear_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/packet_bram_writer.sv
// Streams words through a FIFO into ping-pong BRAM banks, packet-aligned per bank.
// Latency: a word pushed into an empty FIFO appears on the BRAM port the next cycle.
// Backpressure: none upstream; words arriving while full are dropped and counted.
module packet_bram_writer
   import packet_bram_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int BRAM_ADDR_WIDTH  = 16,
   parameter int BRAM_DEPTH_WORDS = 16384,
   parameter int FIFO_DEPTH       = 256,
   parameter int PACKET_WORDS     = 144,
   parameter int NUM_BANKS        = 2
) (
   input  logic                                    clk,
   input  logic                                    rstn,
   input  logic                                    enable,
   input  logic                                    clear,
   input  logic                                    wr_en,
   input  logic [DATA_WIDTH-1:0]                   wr_data,
   output logic                                    full,
   output logic [fifo_cnt_w(FIFO_DEPTH)-1:0]       fifo_count,
   output logic                                    bram_clk,
   output logic                                    bram_rst,
   output logic [BRAM_ADDR_WIDTH-1:0]              bram_addr,
   output logic [DATA_WIDTH-1:0]                   bram_din,
   output logic                                    bram_en,
   output logic [DATA_WIDTH/8-1:0]                 bram_we,
   output logic [clog2_min1(BRAM_DEPTH_WORDS)-1:0] word_addr,
   output logic [31:0]                             packet_count,
   output logic [15:0]                             overflow_count,
   output logic                                    overflow,
   output logic                                    bank_done,
   output logic [clog2_min1(NUM_BANKS)-1:0]        bank_id
);

   localparam int STRIDE = calc_stride(BRAM_DEPTH_WORDS, NUM_BANKS);
   localparam int PPB    = calc_ppb(BRAM_DEPTH_WORDS, NUM_BANKS, PACKET_WORDS);
   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int WA_W   = clog2_min1(BRAM_DEPTH_WORDS);
   localparam int BANK_W = clog2_min1(NUM_BANKS);
   localparam int IDX_W  = clog2_min1(PACKET_WORDS);
   localparam int PIB_W  = clog2_min1(PPB);

   generate
      if (PPB == 0) begin : g_geometry_check
         $error("packet_bram_writer: PACKET_WORDS does not fit in one bank");
      end
   endgenerate

   state_t state_q, state_d;
   logic   start_run;

   logic [WA_W-1:0]            word_addr_q, word_addr_d;
   logic [IDX_W-1:0]           pkt_idx_q, pkt_idx_d;
   logic [PIB_W-1:0]           pib_q, pib_d;
   logic [BANK_W-1:0]          bank_q, bank_d, bank_nxt;
   logic [31:0]                pkt_cnt_q, pkt_cnt_d;
   logic [15:0]                ovf_cnt_q, ovf_cnt_d;
   logic                       ovf_q, ovf_d;
   logic                       bank_done_q, bank_done_d;
   logic [BANK_W-1:0]          bank_id_q, bank_id_d;
   logic                       bram_en_q;
   logic [BYTES-1:0]           bram_we_q;
   logic [DATA_WIDTH-1:0]      bram_din_q, bram_din_d;
   logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;

   logic                  fifo_empty, fifo_full, fifo_wr, fifo_rd;
   logic [DATA_WIDTH-1:0] fifo_rd_data, wr_word;
   logic                  running, push_acc, drop, pop_allow, do_write;

   // Words are accepted only while running; a full FIFO drops the word even if it pops now.
   assign running   = (state_q == ST_RUN);
   assign push_acc  = running & wr_en & ~fifo_full & ~clear;
   assign drop      = running & wr_en & fifo_full & ~clear;
   // Draining is allowed in RUN and DRAIN; clear suppresses the write that cycle.
   assign pop_allow = (state_q != ST_IDLE) & ~clear;
   // An empty FIFO is bypassed so the incoming word reaches the BRAM one cycle later.
   assign do_write  = pop_allow & (~fifo_empty | push_acc);
   assign wr_word   = fifo_empty ? wr_data : fifo_rd_data;
   assign fifo_wr   = push_acc & ~(pop_allow & fifo_empty);
   assign fifo_rd   = pop_allow & ~fifo_empty;

   sync_fifo_fwft #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .clear_i   (clear),
      .wr_en_i   (fifo_wr),
      .wr_data_i (wr_data),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_rd_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full),
      .count_o   (fifo_count)
   );

   // Capture FSM next state; leaving IDLE restarts the write position.
   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d   = ST_RUN;
               start_run = 1'b1;
            end
         end
         ST_RUN: begin
            if (!enable) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (enable)          state_d = ST_RUN;
            else if (fifo_empty) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write position, packet/bank bookkeeping, drop accounting and BRAM port next state.
   always_comb begin
      word_addr_d = word_addr_q;
      pkt_idx_d   = pkt_idx_q;
      pib_d       = pib_q;
      bank_d      = bank_q;
      bank_nxt    = (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + 1'b1;
      pkt_cnt_d   = pkt_cnt_q;
      ovf_cnt_d   = ovf_cnt_q;
      ovf_d       = ovf_q;
      bank_done_d = 1'b0;
      bank_id_d   = bank_id_q;
      bram_din_d  = do_write ? wr_word : bram_din_q;
      bram_addr_d = do_write ? BRAM_ADDR_WIDTH'(32'(word_addr_q) * BYTES) : bram_addr_q;

      if (clear || start_run) begin
         word_addr_d = '0;
         pkt_idx_d   = '0;
         pib_d       = '0;
         bank_d      = '0;
         pkt_cnt_d   = '0;
      end else if (do_write) begin
         if (pkt_idx_q == IDX_W'(PACKET_WORDS - 1)) begin
            pkt_idx_d = '0;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            if (pib_q == PIB_W'(PPB - 1)) begin
               // Last packet of the bank: jump over the bank's unused tail.
               pib_d       = '0;
               bank_d      = bank_nxt;
               bank_done_d = 1'b1;
               bank_id_d   = bank_q;
               word_addr_d = WA_W'(32'(bank_nxt) * STRIDE);
            end else begin
               pib_d       = pib_q + 1'b1;
               word_addr_d = word_addr_q + 1'b1;
            end
         end else begin
            pkt_idx_d   = pkt_idx_q + 1'b1;
            word_addr_d = word_addr_q + 1'b1;
         end
      end

      if (clear) begin
         ovf_cnt_d = '0;
         ovf_d     = 1'b0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
   end

   // State and datapath registers; reset abandons any write in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         word_addr_q <= '0;
         pkt_idx_q   <= '0;
         pib_q       <= '0;
         bank_q      <= '0;
         pkt_cnt_q   <= '0;
         ovf_cnt_q   <= '0;
         ovf_q       <= 1'b0;
         bank_done_q <= 1'b0;
         bank_id_q   <= '0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= '0;
         bram_din_q  <= '0;
         bram_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         word_addr_q <= word_addr_d;
         pkt_idx_q   <= pkt_idx_d;
         pib_q       <= pib_d;
         bank_q      <= bank_d;
         pkt_cnt_q   <= pkt_cnt_d;
         ovf_cnt_q   <= ovf_cnt_d;
         ovf_q       <= ovf_d;
         bank_done_q <= bank_done_d;
         bank_id_q   <= bank_id_d;
         bram_en_q   <= do_write;
         bram_we_q   <= {BYTES{do_write}};
         bram_din_q  <= bram_din_d;
         bram_addr_q <= bram_addr_d;
      end
   end

   assign full           = fifo_full;
   assign bram_clk       = clk;
   assign bram_rst       = ~rstn;
   assign bram_addr      = bram_addr_q;
   assign bram_din       = bram_din_q;
   assign bram_en        = bram_en_q;
   assign bram_we        = bram_we_q;
   assign word_addr      = word_addr_q;
   assign packet_count   = pkt_cnt_q;
   assign overflow_count = ovf_cnt_q;
   assign overflow       = ovf_q;
   assign bank_done      = bank_done_q;
   assign bank_id        = bank_id_q;

endmodule

// File: doc/packet_bram_writer.md
PACKET_BRAM_WRITER -- requirements
Module: packet_bram_writer

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_WIDTH, 32, word width; multiple of 8.
- BRAM_ADDR_WIDTH, 16, BRAM byte-address width.
- BRAM_DEPTH_WORDS, 16384, BRAM depth in words.
- FIFO_DEPTH, 256, FIFO entries; power of 2.
- PACKET_WORDS, 144, words per packet.
- NUM_BANKS, 2, ping-pong banks; power of 2.
REQ-002 SHALL have ports, one per line; clk and rstn are listed first:
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = capture and write.
- clear  in  1  single-cycle pulse: flush and zero all state.
- wr_en  in  1  push wr_data.
- wr_data  in  DATA_WIDTH  data word.
- full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy.
- bram_clk  out  1  equals clk.
- bram_rst  out  1  equals ~rstn.
- bram_addr  out  BRAM_ADDR_WIDTH  byte address.
- bram_din  out  DATA_WIDTH  write data.
- bram_en  out  1  BRAM enable.
- bram_we  out  DATA_WIDTH/8  byte write enables.
- word_addr  out  $clog2(BRAM_DEPTH_WORDS)  next word address to be written.
- packet_count  out  32  completed packets since start.
- overflow_count  out  16  dropped words; saturates at 0xFFFF.
- overflow  out  1  sticky drop flag.
- bank_done  out  1  one-cycle pulse when a bank fills.
- bank_id  out  $clog2(NUM_BANKS)  bank just completed; valid during bank_done.

Function
REQ-003 SHALL derive STRIDE = BRAM_DEPTH_WORDS/NUM_BANKS and PPB = floor(STRIDE/PACKET_WORDS); elaboration SHALL error if PPB = 0.
REQ-004 SHALL implement the FSM states IDLE, RUN and DRAIN.
- IDLE->RUN: on enable=1.
- RUN->DRAIN: on enable=0.
- DRAIN->IDLE: when the FIFO is empty.
- DRAIN->RUN: on enable=1.
REQ-005 SHALL, on the IDLE->RUN transition, set word_addr to 0 and the packet word index to 0, and zero packet_count.
REQ-006 SHALL accept wr_en only in RUN; wr_en in IDLE or DRAIN SHALL be ignored and SHALL NOT be counted.
REQ-007 SHALL drop the word when wr_en=1 and full=1, where full is the registered value at the start of that cycle. This holds even if a pop occurs in the same cycle. Each drop SHALL increment overflow_count (saturating) and set overflow.
REQ-008 SHALL leave fifo_count unchanged on a simultaneous push and pop while not full.
REQ-009 SHALL pop one word per cycle whenever the FIFO is non-empty in RUN or DRAIN (throughput 1 word/clk).
REQ-010 SHALL present a word pushed at cycle N into an empty FIFO on the BRAM port at cycle N+1. The BRAM outputs are registered:
- bram_en = 1.
- bram_we = all ones.
- bram_din = the word.
- bram_addr = word_addr*(DATA_WIDTH/8).
REQ-011 SHALL drive bram_en=0 and bram_we=0 in every cycle without a pop.
REQ-012 SHALL, after each write, increment word_addr and the packet word index. When the index reaches PACKET_WORDS, the index SHALL return to 0 and packet_count SHALL increment.
REQ-013 SHALL, when the packet completed by a write is packet PPB-1 of the current bank, do all of the following:
- Pulse bank_done in the next cycle, with bank_id = that bank.
- Set word_addr to the next bank base ((bank+1) mod NUM_BANKS)*STRIDE, skipping the STRIDE-PPB*PACKET_WORDS unused words.
REQ-014 SHALL handle enable=0 mid-packet by writing every queued word (DRAIN), leaving word_addr where it stopped.
REQ-015 SHALL, on clear, in the following cycle:
- Empty the FIFO.
- Zero word_addr, the packet word index, packet_count, overflow_count and overflow.
- Leave the FSM state unchanged.
clear SHALL take priority over a simultaneous push or pop.

Reset
REQ-016 SHALL, while rstn=0, asynchronously force:
- state IDLE, FIFO empty, full=0, fifo_count=0.
- bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
- word_addr=0, packet_count=0, overflow_count=0, overflow=0.
- bank_done=0, bank_id=0.
REQ-017 SHALL abandon any in-flight write when reset asserts mid-packet; no partial state SHALL persist after rstn rises.

Structure
REQ-018 SHALL place the FSM state enum and the derived-constant helpers (STRIDE, PPB, the clog2 widths) in the shared package packet_bram_pkg.
REQ-019 SHALL implement the FIFO as one sub-module, sync_fifo_fwft (first-word fall-through, with count and full outputs, and a clear input).

Verification
Bench configuration for all scenarios: DATA_WIDTH=32, BRAM_DEPTH_WORDS=40, NUM_BANKS=2, PACKET_WORDS=6, FIFO_DEPTH=8 (STRIDE=20, PPB=3).
REQ-020 SHALL cover:
- Latency: push 0xA5A5A5A5 at cycle N -> bram_en=1, bram_addr=0x0, bram_din=0xA5A5A5A5 at cycle N+1.
- Bank skip: stream 36 words -> bank_done with bank_id=0 after word 18; word 19 written at byte address 0x50; bank_id=1 after word 36; word_addr returns to 0; packet_count=6.
- Overflow: enable=1 with the drain blocked (FIFO filled in one burst while the pop is held off by the bench) -> after 8 pushes full=1; 3 more pushes give overflow_count=3 and overflow=1; no extra BRAM writes occur.
- Drain: enable falls after 4 queued words -> exactly 4 writes occur, then IDLE; later wr_en produces no writes.
- Clear: clear with 5 words queued -> fifo_count=0, word_addr=0 and counters zero next cycle; no further writes.
- Reset: rstn low mid-packet -> all outputs go to reset values within the same cycle; after release the first write goes to address 0.
